// File: rtl/cpu_pkg.sv
// Shared widths, ALU select encodings and the operand bundle handed to the ALU.
package cpu_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 3;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;
  localparam int SEL_WIDTH  = 3;

  localparam logic [SEL_WIDTH-1:0] SEL_FWD = 3'b000;
  localparam logic [SEL_WIDTH-1:0] SEL_ADD = 3'b001;
  localparam logic [SEL_WIDTH-1:0] SEL_AND = 3'b010;
  localparam logic [SEL_WIDTH-1:0] SEL_OR  = 3'b011;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data1;
    logic [DATA_WIDTH-1:0] data2;
    logic [SEL_WIDTH-1:0]  select;
  } operand_t;

  function automatic logic [DATA_WIDTH-1:0] twos_neg(input logic [DATA_WIDTH-1:0] v);
    return ~v + DATA_WIDTH'(1);
  endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: two combinational read ports, one synchronous write port, async clear.
module reg_file
  import cpu_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = ADDR_WIDTH,
  parameter int NR = NUM_REGS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic [DW-1:0] rd_data1,
  output logic [DW-1:0] rd_data2,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);

  logic [DW-1:0] regs [NR];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data1 = regs[rd_addr1];
  assign rd_data2 = regs[rd_addr2];

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: register read with writeback bypass, immediate/negate mux for
// operand 2, and a one-entry valid/ready output buffer toward the ALU.
//
//   state | meaning
//   EMPTY | no beat buffered, OUT_VALID=0
//   FULL  | beat buffered on DATA1/DATA2/SELECT, OUT_VALID=1
module operand_fetch_stage
  import cpu_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [SEL_WIDTH-1:0]  OPCODE_SEL,
  input  logic [ADDR_WIDTH-1:0] READREG1,
  input  logic [ADDR_WIDTH-1:0] READREG2,
  input  logic [DATA_WIDTH-1:0] IMMEDIATE,
  input  logic                  IMM_SEL,
  input  logic                  NEG_SEL,
  input  logic [ADDR_WIDTH-1:0] WRITEREG,
  input  logic [DATA_WIDTH-1:0] WRITEDATA,
  input  logic                  WRITEENABLE,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] DATA1,
  output logic [DATA_WIDTH-1:0] DATA2,
  output logic [SEL_WIDTH-1:0]  SELECT
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                state;
  operand_t              buf_q;
  operand_t              next_beat;
  logic [DATA_WIDTH-1:0] rf_rd1, rf_rd2;
  logic [DATA_WIDTH-1:0] rd1, rd2, src2;
  logic                  accept;

  reg_file u_reg_file (
    .clk      (CLK),
    .rst_n    (RESET),
    .rd_addr1 (READREG1),
    .rd_addr2 (READREG2),
    .rd_data1 (rf_rd1),
    .rd_data2 (rf_rd2),
    .wr_en    (WRITEENABLE),
    .wr_addr  (WRITEREG),
    .wr_data  (WRITEDATA)
  );

  // A same-cycle write wins over the stale register contents.
  assign rd1  = (WRITEENABLE && WRITEREG == READREG1) ? WRITEDATA : rf_rd1;
  assign rd2  = (WRITEENABLE && WRITEREG == READREG2) ? WRITEDATA : rf_rd2;
  assign src2 = IMM_SEL ? IMMEDIATE : rd2;

  always_comb begin
    next_beat        = '0;
    next_beat.data1  = rd1;
    next_beat.data2  = NEG_SEL ? twos_neg(src2) : src2;
    next_beat.select = OPCODE_SEL;
  end

  assign OUT_VALID = (state == FULL);
  assign IN_READY  = RESET & (~OUT_VALID | OUT_READY);
  assign accept    = IN_VALID & IN_READY;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= EMPTY;
      buf_q <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            buf_q <= next_beat;
            state <= FULL;
          end
        end
        FULL: begin
          if (OUT_READY) begin
            if (accept) buf_q <= next_beat;
            else        state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign DATA1  = buf_q.data1;
  assign DATA2  = buf_q.data2;
  assign SELECT = buf_q.select;

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
Operand-fetch stage directly upstream of the 8-bit ALU. It holds an 8x8 register file and reads two source registers. It forms DATA2 from either a register or an immediate, with optional two's-complement negation for subtract. The resulting DATA1, DATA2 and SELECT are registered into a one-entry output buffer with a valid/ready handshake toward the ALU; the writeback port returns results into the register file.

Parameters:
DATA_WIDTH, 8, operand/register width
ADDR_WIDTH, 3, register address width
NUM_REGS, 8, register count (= 2**ADDR_WIDTH)
SEL_WIDTH, 3, ALU select width

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-low reset
IN_VALID  in  1  upstream instruction fields valid
IN_READY  out  1  stage can accept this cycle
OPCODE_SEL  in  SEL_WIDTH  ALU select to pass through
READREG1  in  ADDR_WIDTH  source register for DATA1
READREG2  in  ADDR_WIDTH  source register for DATA2
IMMEDIATE  in  DATA_WIDTH  immediate operand
IMM_SEL  in  1  1: DATA2 source is IMMEDIATE
NEG_SEL  in  1  1: negate the DATA2 source
WRITEREG  in  ADDR_WIDTH  writeback destination
WRITEDATA  in  DATA_WIDTH  writeback value
WRITEENABLE  in  1  writeback strobe
OUT_VALID  out  1  DATA1/DATA2/SELECT valid to ALU
OUT_READY  in  1  ALU consumes this cycle
DATA1  out  DATA_WIDTH  ALU operand 1
DATA2  out  DATA_WIDTH  ALU operand 2
SELECT  out  SEL_WIDTH  ALU select

Behaviour:
- Reset is asynchronous and active-low. While RESET=0: all registers = 0x00, OUT_VALID=0, DATA1=DATA2=0x00, SELECT=0, IN_READY=0. All elements leave reset on the first CLK edge after RESET=1.
- Register file:
  - Combinational read on both ports.
  - Write on rising CLK when WRITEENABLE=1.
  - R0 is an ordinary register and is not hard-wired to zero.
  - Writes are independent of the handshake and proceed during stalls.
- Bypass: if WRITEENABLE=1 and WRITEREG equals READREGx in the same cycle, that operand uses WRITEDATA instead of the stale register value.
- Operand 2 path: src = IMM_SEL ? IMMEDIATE : rf[READREG2] (after bypass), then op2 = NEG_SEL ? (~src + 1) mod 2**DATA_WIDTH : src. Edge cases: 0x00 -> 0x00, 0x80 -> 0x80, no overflow flag.
- Output buffer uses a two-state FSM, EMPTY (OUT_VALID=0) and FULL (OUT_VALID=1).
  - IN_READY = RESET & (~OUT_VALID | OUT_READY), combinational.
  - Accept = IN_VALID & IN_READY at the rising edge: DATA1 <= rd1, DATA2 <= op2, SELECT <= OPCODE_SEL, OUT_VALID <= 1.
  - EMPTY -> FULL on accept.
  - FULL -> FULL when OUT_READY & accept (back-to-back, one beat per cycle).
  - FULL -> EMPTY when OUT_READY & ~accept.
  - While FULL & ~OUT_READY: DATA1, DATA2 and SELECT hold stable and nothing is accepted.
- Latency: 1 cycle from accept to OUT_VALID with the data. Register values are sampled at the accept edge; later writes do not alter a buffered beat.
- Simultaneous write and accept to the same register: the buffered operand carries WRITEDATA, and the register also updates.
- Reset mid-operation: the buffered beat is discarded immediately (OUT_VALID falls asynchronously) and all register contents are lost.

Decomposition:
- Shared package cpu_pkg:
  - DATA_WIDTH, ADDR_WIDTH, SEL_WIDTH constants.
  - ALU select encodings: FWD=000, ADD=001, AND=010, OR=011.
  - Typedef for the operand bundle {DATA1, DATA2, SELECT}.
- One sub-module, reg_file: 8x8 array, two combinational read ports, one synchronous write port, async active-low clear. Bypass, negation mux and handshake FSM stay in operand_fetch_stage.

Test Plan:
- Reset: hold RESET=0 for 2 cycles, release -> OUT_VALID=0, IN_READY=1, READREG1/2 = 0..7 all yield 0x00 operands.
- Immediate add: write R2=0x05; then IN_VALID=1, READREG1=2, IMM_SEL=1, IMMEDIATE=0x03, NEG_SEL=0, OPCODE_SEL=001 -> next cycle DATA1=0x05, DATA2=0x03, SELECT=001, OUT_VALID=1.
- Negation: R3=0x15, R4=0x45; fetch READREG1=3, READREG2=4, NEG_SEL=1 -> DATA1=0x15, DATA2=0xBB. Also immediate 0x80 with NEG_SEL=1 -> DATA2=0x80.
- Bypass: same cycle WRITEENABLE=1, WRITEREG=5, WRITEDATA=0xA5 and accept READREG1=5 -> DATA1=0xA5; next fetch of R5 also returns 0xA5.
- Stall: OUT_READY=0 for 3 cycles with IN_VALID=1 and new fields -> IN_READY=0, DATA1/DATA2/SELECT unchanged. OUT_READY=1 -> new beat appears the following cycle with no beat lost or duplicated; a back-to-back stream sustains 1 beat/cycle.
- Reset mid-operation: with OUT_VALID=1 and R1=0x73, pulse RESET=0 between edges -> OUT_VALID=0 immediately; after release, R1 reads 0x00.
